// File: rtl/pong_pkg.sv
// Shared Pong definitions: match FSM encoding, playfield geometry and score width.
// Every stage of the game pipeline imports this package.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int X_W     = 7;   // columns 0..127
  localparam int Y_W     = 6;   // rows 0..63
  localparam int SCORE_W = 4;

  localparam logic [X_W-1:0] CENTRE_X = 7'd64;
  localparam logic [Y_W-1:0] CENTRE_Y = 6'd32;

  // Goal classification of a ball row; the top goal wins if the rows overlap.
  // Bit 0: goal for player 1 (top row reached), bit 1: goal for player 2.
  function automatic logic [1:0] goal_side(input logic [Y_W-1:0] y,
                                           input logic [Y_W-1:0] top_y,
                                           input logic [Y_W-1:0] bot_y);
    logic [1:0] r;
    r = 2'b00;
    if (y <= top_y)      r = 2'b01;
    else if (y >= bot_y) r = 2'b10;
    return r;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Load/count-down timer: after a load, done is high on the CYCLES-th enabled
// clock, and the counter reaches zero on that same edge.
module delay_timer #(
  parameter  int CYCLES = 1,
  localparam int W      = $clog2(CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (load)               r_cnt <= W'(CYCLES);
    else if (en && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign done = en && (r_cnt == W'(1));

endmodule

// File: rtl/game_control.sv
// Pong match controller: goal detection from the ball row, scoring, serve delay
// and winner declaration. ball_rst is ORed with system reset for the ball stage.
module game_control
  import pong_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int SERVE_MS   = 1000,
  parameter int WIN_SCORE  = 7,
  parameter int TOP_GOAL_Y = 0,
  parameter int BOT_GOAL_Y = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [Y_W-1:0]     ballY,
  output logic               ball_rst,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               goal_pulse,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam int                 SERVE_CYC = CLK_HZ / 1000 * SERVE_MS;
  localparam logic [Y_W-1:0]     TOP_Y     = Y_W'(TOP_GOAL_Y);
  localparam logic [Y_W-1:0]     BOT_Y     = Y_W'(BOT_GOAL_Y);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic               r_ball_rst;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic               r_goal_pulse;
  logic               r_game_over;
  logic               r_winner;
  logic               r_scorer;   // who scored the goal being processed

  logic [1:0] w_goal;
  logic       w_win;
  logic       w_start_ok;
  logic       w_tmr_load;
  logic       w_tmr_en;
  logic       w_tmr_done;

  assign w_goal     = goal_side(ballY, TOP_Y, BOT_Y);
  // Scores were already bumped on entry to GOAL, so this sees the new count.
  assign w_win      = r_scorer ? (r_score2 == WIN) : (r_score1 == WIN);
  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_OVER);
  assign w_tmr_load = w_start_ok || (r_state == ST_GOAL && !w_win);
  assign w_tmr_en   = (r_state == ST_SERVE);

  delay_timer #(.CYCLES(SERVE_CYC)) u_serve_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (w_tmr_load),
    .en   (w_tmr_en),
    .done (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ball_rst   <= 1'b1;
      r_score1     <= '0;
      r_score2     <= '0;
      r_goal_pulse <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= 1'b0;
      r_scorer     <= 1'b0;
    end else begin
      r_goal_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ball_rst <= 1'b1;
          if (start) begin
            r_score1 <= '0;
            r_score2 <= '0;
            r_state  <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (w_tmr_done) begin
            r_state    <= ST_PLAY;
            r_ball_rst <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (w_goal[0]) begin
            r_score1     <= r_score1 + 1'b1;
            r_scorer     <= 1'b0;
            r_state      <= ST_GOAL;
            r_goal_pulse <= 1'b1;
            r_ball_rst   <= 1'b1;
          end else if (w_goal[1]) begin
            r_score2     <= r_score2 + 1'b1;
            r_scorer     <= 1'b1;
            r_state      <= ST_GOAL;
            r_goal_pulse <= 1'b1;
            r_ball_rst   <= 1'b1;
          end
        end
        ST_GOAL: begin
          if (w_win) begin
            r_state     <= ST_OVER;
            r_game_over <= 1'b1;
            r_winner    <= r_scorer;
          end else begin
            r_state <= ST_SERVE;
          end
        end
        ST_OVER: begin
          if (start) begin
            r_score1    <= '0;
            r_score2    <= '0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_state     <= ST_SERVE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ball_rst <= 1'b1;
        end
      endcase
    end
  end

  assign ball_rst   = r_ball_rst;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign goal_pulse = r_goal_pulse;
  assign game_over  = r_game_over;
  assign winner     = r_winner;
  assign state      = r_state;

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: a match-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_game_control;

  localparam int SERVE_CYC = 5;
  localparam int WIN       = 3;
  localparam int TOP       = 0;
  localparam int BOT       = 63;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] ballY;
  logic       ball_rst;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       goal_pulse;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  game_control #(
    .CLK_HZ(1000), .SERVE_MS(5), .WIN_SCORE(WIN),
    .TOP_GOAL_Y(TOP), .BOT_GOAL_Y(BOT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ballY(ballY),
    .ball_rst(ball_rst), .score1(score1), .score2(score2),
    .goal_pulse(goal_pulse), .game_over(game_over), .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  // Match model: phase 0 idle, 1 serving, 2 rally, 3 goal, 4 match over.
  int m_ph   = 0;
  int m_s1   = 0;
  int m_s2   = 0;
  int m_left = 0;
  int m_over = 0;
  int m_win  = 0;
  int m_who  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0; m_s1 <= 0; m_s2 <= 0; m_left <= 0;
      m_over <= 0; m_win <= 0; m_who <= 0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_s1 <= 0; m_s2 <= 0; m_left <= SERVE_CYC; m_ph <= 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_ph <= 2;
        end
        2: if (int'(ballY) <= TOP) begin
          m_s1 <= m_s1 + 1; m_who <= 0; m_ph <= 3;
        end else if (int'(ballY) >= BOT) begin
          m_s2 <= m_s2 + 1; m_who <= 1; m_ph <= 3;
        end
        3: if ((m_who == 1 ? m_s2 : m_s1) == WIN) begin
          m_ph <= 4; m_over <= 1; m_win <= m_who;
        end else begin
          m_ph <= 1; m_left <= SERVE_CYC;
        end
        4: if (start) begin
          m_s1 <= 0; m_s2 <= 0; m_over <= 0; m_win <= 0;
          m_left <= SERVE_CYC; m_ph <= 1;
        end
        default: m_ph <= 0;
      endcase
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("m_state",    int'(state),      m_ph);
    check("m_ball_rst", int'(ball_rst),   (m_ph != 2) ? 1 : 0);
    check("m_score1",   int'(score1),     m_s1);
    check("m_score2",   int'(score2),     m_s2);
    check("m_pulse",    int'(goal_pulse), (m_ph == 3) ? 1 : 0);
    check("m_over",     int'(game_over),  m_over);
    check("m_winner",   int'(winner),     m_win);
  endtask

  // One clock: outputs are compared on the falling edge, inputs change after.
  task automatic step();
    @(negedge clk);
    cmp_model();
  endtask

  // Called with SERVE already visible; SERVE lasts 5 samples, then PLAY.
  task automatic serve_wait();
    repeat (SERVE_CYC - 1) step();
    step();
    check("reach_play", int'(state), 2);
  endtask

  // Goal from PLAY, then one more clock into SERVE or OVER.
  task automatic goal(input logic [5:0] y);
    ballY = y;
    step();
    ballY = 6'd32;
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ballY = 6'd32;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_state",  int'(state), 0);
    check("rst_brst",   int'(ball_rst), 1);
    check("rst_s1",     int'(score1), 0);
    check("rst_s2",     int'(score2), 0);
    check("rst_over",   int'(game_over), 0);

    start = 1'b1; step(); start = 1'b0;
    check("start_serve", int'(state), 1);
    check("serve_brst",  int'(ball_rst), 1);
    serve_wait();
    check("play_brst", int'(ball_rst), 0);

    ballY = 6'd0; step();
    check("g1_state", int'(state), 3);
    check("g1_pulse", int'(goal_pulse), 1);
    check("g1_s1",    int'(score1), 1);
    check("g1_brst",  int'(ball_rst), 1);
    ballY = 6'd32; step();
    check("g1_serve", int'(state), 1);
    check("g1_pulse_off", int'(goal_pulse), 0);
    serve_wait();

    // P2 goal, then hold the ball in the goal row through SERVE
    ballY = 6'd63; step();
    check("g2_s2", int'(score2), 1);
    check("g2_s1", int'(score1), 1);
    step();
    serve_wait();
    check("hold_s2", int'(score2), 1);
    step();
    check("g3_s2", int'(score2), 2);
    ballY = 6'd32; step();
    serve_wait();
    ballY = 6'd63; step();
    check("g4_s2", int'(score2), 3);
    step();
    check("win2_state",  int'(state), 4);
    check("win2_over",   int'(game_over), 1);
    check("win2_winner", int'(winner), 1);
    repeat (3) step();
    check("frozen_s1", int'(score1), 1);
    check("frozen_s2", int'(score2), 3);
    ballY = 6'd32; start = 1'b1; step(); start = 1'b0;
    check("restart_state", int'(state), 1);
    check("restart_s1",    int'(score1), 0);
    check("restart_s2",    int'(score2), 0);
    check("restart_over",  int'(game_over), 0);

    // Reset in the 3rd SERVE clock with scores 2/1
    serve_wait(); goal(6'd0);
    serve_wait(); goal(6'd0);
    serve_wait(); goal(6'd63);
    check("pre_rst_s1", int'(score1), 2);
    check("pre_rst_s2", int'(score2), 1);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_state", int'(state), 0);
    check("midrst_s1",    int'(score1), 0);
    check("midrst_s2",    int'(score2), 0);
    check("midrst_brst",  int'(ball_rst), 1);

    // Player 1 takes the match
    start = 1'b1; step(); start = 1'b0;
    serve_wait(); goal(6'd0);
    serve_wait(); goal(6'd0);
    serve_wait(); goal(6'd0);
    check("win1_state",  int'(state), 4);
    check("win1_winner", int'(winner), 0);
    check("win1_s1",     int'(score1), 3);

    start = 1'b1; step(); start = 1'b0;
    check("over_restart", int'(state), 1);

    // Long rally with the ball mid-field
    serve_wait();
    ballY = 6'd32;
    repeat (1000) step();
    check("rally_state", int'(state), 2);
    check("rally_pulse", int'(goal_pulse), 0);
    check("rally_brst",  int'(ball_rst), 0);
    check("rally_s1",    int'(score1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
